// File: rtl/pc_pkg.sv
// Shared opcode definitions for the program-counter / return-stack unit.
package pc_pkg;

  localparam int unsigned OP_W = 3;

  // PC_FS operation codes; codes 6 and 7 are reserved and behave as hold.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_RSVD6  = 3'b110,
    OP_RSVD7  = 3'b111
  } pc_op_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO storage with occupancy count and full/empty flags.
// Entry contents are not reset; only the occupancy count is.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [CW-1:0]    count_dec;

  assign count_dec = count - CW'(1);
  assign wr_idx    = count[AW-1:0];
  assign rd_idx    = count_dec[AW-1:0];
  assign top       = mem[rd_idx];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // Write the pushed value into the next free slot.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  // Track occupancy; push and pop are never requested together by the caller.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count_dec;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with increment, relative branch, absolute jump, and
// call/return through a return-address stack, plus sticky stack error flags.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      SHIFT        = 2,
  parameter int unsigned      DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [2:0]             PC_FS,
  input  logic [WIDTH-1:0]       offset,
  input  logic [WIDTH-1:0]       in_addr,
  input  logic                   err_clear,
  output logic [WIDTH-1:0]       PC_out,
  output logic [WIDTH-1:0]       PC_next_seq,
  output logic [$clog2(DEPTH):0] stack_count,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ALL_ONES << SHIFT;
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(1) << SHIFT;

  pc_op_e           op;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] stack_top;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             unf_set;

  assign op          = pc_op_e'(PC_FS);
  assign target      = in_addr & ALIGN_MASK;
  assign PC_next_seq = PC_out + STEP;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (PC_next_seq),
    .top   (stack_top),
    .count (stack_count),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Decode the operation into the next PC, stack requests and error events.
  always_comb begin
    pc_next = PC_out;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      unique case (op)
        OP_INC:    pc_next = PC_next_seq;
        OP_BRANCH: pc_next = PC_out + (offset << SHIFT);
        OP_JUMP:   pc_next = target;
        OP_CALL: begin
          if (stack_full) begin
            ovf_set = 1'b1;
          end else begin
            push    = 1'b1;
            pc_next = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            unf_set = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_next = stack_top;
          end
        end
        default: pc_next = PC_out;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      PC_out <= RESET_VECTOR;
    end else begin
      PC_out <= pc_next;
    end
  end

  // Sticky error flags: a new error beats a simultaneous clear; clear ignores en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (err_clear) overflow <= 1'b0;
      if (unf_set)        underflow <= 1'b1;
      else if (err_clear) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed table, hand sequences for
// stack overflow/underflow and asynchronous reset, then randomized traffic
// compared against a queue-based reference model.
module tb_pc_stack_unit;
  import pc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  PC_FS;
  logic [31:0] offset;
  logic [31:0] in_addr;
  logic        err_clear;
  logic [31:0] PC_out;
  logic [31:0] PC_next_seq;
  logic [3:0]  stack_count;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;

  pc_stack_unit #(
    .WIDTH        (32),
    .SHIFT        (2),
    .DEPTH        (8),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .PC_FS       (PC_FS),
    .offset      (offset),
    .in_addr     (in_addr),
    .err_clear   (err_clear),
    .PC_out      (PC_out),
    .PC_next_seq (PC_next_seq),
    .stack_count (stack_count),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  // Reference model: PC value, a queue as the stack, two sticky bits.
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_ovf;
  bit          m_unf;

  task automatic model_reset();
    m_pc = 32'h0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit e, input logic [2:0] fs, input logic [31:0] off,
                            input logic [31:0] addr, input bit clr);
    bit os = 0;
    bit us = 0;
    if (e) begin
      case (fs)
        3'd1: m_pc = m_pc + 32'd4;
        3'd2: m_pc = m_pc + off * 32'd4;
        3'd3: m_pc = addr & 32'hFFFF_FFFC;
        3'd4: begin
          if (m_stk.size() < 8) begin
            m_stk.push_back(m_pc + 32'd4);
            m_pc = addr & 32'hFFFF_FFFC;
          end else os = 1;
        end
        3'd5: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else us = 1;
        end
        default: ;
      endcase
    end
    m_ovf = os ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = us ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = m_stk.size();
    chk({tag, " pc"},    PC_out, m_pc);
    chk({tag, " nseq"},  PC_next_seq, m_pc + 32'd4);
    chk({tag, " count"}, 32'(stack_count), 32'(sz));
    chk({tag, " full"},  32'(stack_full), 32'(sz == 8));
    chk({tag, " empty"}, 32'(stack_empty), 32'(sz == 0));
    chk({tag, " ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, " unf"},   32'(underflow), 32'(m_unf));
  endtask

  // Drive one set of inputs, let one rising edge happen, sample 1 time unit later.
  task automatic step(input bit e, input logic [2:0] fs, input logic [31:0] off,
                      input logic [31:0] addr, input bit clr);
    en = e; PC_FS = fs; offset = off; in_addr = addr; err_clear = clr;
    @(posedge clock);
    model_step(e, fs, off, addr, clr);
    #1;
  endtask

  typedef struct {
    bit          e;
    logic [2:0]  fs;
    logic [31:0] off;
    logic [31:0] addr;
    bit          clr;
    logic [31:0] pc;
    int          cnt;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit e, logic [2:0] fs, logic [31:0] off, logic [31:0] addr,
                              bit clr, logic [31:0] pc, int cnt, bit ovf, bit unf);
    vec_t v;
    v.e = e; v.fs = fs; v.off = off; v.addr = addr; v.clr = clr;
    v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  logic [31:0] ra[8];
  logic [31:0] exp_pc;

  initial begin
    tbl[0]  = mk(1, OP_INC,    0,            0,         0, 32'h4,        0, 0, 0);
    tbl[1]  = mk(1, OP_INC,    0,            0,         0, 32'h8,        0, 0, 0);
    tbl[2]  = mk(1, OP_INC,    0,            0,         0, 32'hC,        0, 0, 0);
    tbl[3]  = mk(1, OP_BRANCH, 32'hFFFFFFFE, 0,         0, 32'h4,        0, 0, 0);
    tbl[4]  = mk(1, OP_JUMP,   0,            0,         0, 32'h0,        0, 0, 0);
    tbl[5]  = mk(1, OP_BRANCH, 32'hFFFFFFFF, 0,         0, 32'hFFFFFFFC, 0, 0, 0);
    tbl[6]  = mk(1, OP_JUMP,   0,            32'h23,    0, 32'h20,       0, 0, 0);
    tbl[7]  = mk(1, OP_CALL,   0,            32'h103,   0, 32'h100,      1, 0, 0);
    tbl[8]  = mk(1, OP_RET,    0,            0,         0, 32'h24,       0, 0, 0);
    tbl[9]  = mk(0, OP_INC,    0,            0,         0, 32'h24,       0, 0, 0);
    tbl[10] = mk(1, OP_RSVD6,  32'h7,        32'h77,    0, 32'h24,       0, 0, 0);
    tbl[11] = mk(1, OP_RSVD7,  32'h7,        32'h77,    0, 32'h24,       0, 0, 0);
    tbl[12] = mk(1, OP_RET,    0,            0,         0, 32'h24,       0, 0, 1);
    tbl[13] = mk(0, OP_HOLD,   0,            0,         1, 32'h24,       0, 0, 0);
    tbl[14] = mk(1, OP_RET,    0,            0,         1, 32'h24,       0, 0, 1);
    tbl[15] = mk(1, OP_HOLD,   0,            0,         1, 32'h24,       0, 0, 0);
    tbl[16] = mk(0, OP_CALL,   0,            32'h500,   0, 32'h24,       0, 0, 0);

    reset = 1'b1; en = 1'b0; PC_FS = OP_HOLD; offset = '0; in_addr = '0; err_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    chk("reset pc", PC_out, 32'h0);
    chk("reset count", 32'(stack_count), 32'h0);
    chk("reset empty", 32'(stack_empty), 32'h1);
    chk("reset full", 32'(stack_full), 32'h0);
    chk("reset flags", {30'h0, overflow, underflow}, 32'h0);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].e, tbl[i].fs, tbl[i].off, tbl[i].addr, tbl[i].clr);
      chk($sformatf("tbl%0d pc", i), PC_out, tbl[i].pc);
      chk($sformatf("tbl%0d count", i), 32'(stack_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d unf", i), 32'(underflow), 32'(tbl[i].unf));
    end

    // Fill the stack with eight calls, then overflow with a ninth.
    exp_pc = 32'h24;
    for (int i = 0; i < 8; i++) begin
      ra[i] = exp_pc + 32'd4;
      exp_pc = 32'h1000 * (i + 1);
      step(1, OP_CALL, 0, exp_pc | 32'h3, 0);
      chk($sformatf("fill%0d pc", i), PC_out, exp_pc);
      chk($sformatf("fill%0d count", i), 32'(stack_count), 32'(i + 1));
    end
    step(1, OP_CALL, 0, 32'h9000, 0);
    chk("ovf9 pc", PC_out, 32'h8000);
    chk("ovf9 full", 32'(stack_full), 32'h1);
    chk("ovf9 flag", 32'(overflow), 32'h1);
    chk("ovf9 count", 32'(stack_count), 32'h8);
    for (int i = 7; i >= 0; i--) begin
      step(1, OP_RET, 0, 0, 0);
      chk($sformatf("pop%0d pc", i), PC_out, ra[i]);
    end
    chk("drain empty", 32'(stack_empty), 32'h1);
    chk("ovf sticky", 32'(overflow), 32'h1);
    step(0, OP_HOLD, 0, 0, 1);
    chk("ovf cleared", 32'(overflow), 32'h0);

    // Asynchronous reset landing between edges while a call is pending.
    step(1, OP_CALL, 0, 32'h300, 0);
    step(1, OP_CALL, 0, 32'h400, 0);
    chk("pre-reset count", 32'(stack_count), 32'h2);
    en = 1'b1; PC_FS = OP_CALL; in_addr = 32'h600;
    #3 reset = 1'b1;
    #1;
    chk("async reset pc", PC_out, 32'h0);
    chk("async reset count", 32'(stack_count), 32'h0);
    chk("async reset empty", 32'(stack_empty), 32'h1);
    #1 reset = 1'b0;
    model_reset();
    step(1, OP_CALL, 0, 32'h600, 0);
    chk("post-reset call pc", PC_out, 32'h600);
    chk("post-reset call count", 32'(stack_count), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, OP_INC, 0, 0, 0);
      chk($sformatf("en0 hold%0d", i), PC_out, 32'h600);
    end
    check_model("dir");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  fs;
      logic [31:0] off;
      fs  = 3'($urandom_range(0, 7));
      off = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      step($urandom_range(0, 9) != 0, fs, off, $urandom, $urandom_range(0, 15) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
